// File: rtl/uart_bridge_pkg.sv
// Shared register map, STATUS/IRQ_EN bit positions and TX drain FSM states
// for the uart_bridge block.
package uart_bridge_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_BAUD   = 4'h8;
  localparam logic [3:0] REG_IRQ_EN = 4'hC;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_BUSY       = 4;

  localparam int IE_RX = 0;
  localparam int IE_TX = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/uart_bridge_fifo.sv
// Synchronous FIFO with first-word fall-through output. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // The extra pointer MSB distinguishes full from empty when indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bridge.sv
// Memory-mapped front end for the Uart engine: TX/RX FIFOs, STATUS and BAUD
// registers. Optional interrupt output and 0xC register via UART_BRIDGE_IRQ_EN.
module uart_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
  parameter logic [31:0] BAUD_RST = 32'd115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        u_write_enable,
  output logic [7:0]  u_data,
  input  logic        u_busy,
  input  logic [7:0]  u_rx_data,
  input  logic        u_out_valid,
  output logic [31:0] baud_rate,
  output logic [31:0] clk_frequency
`ifdef UART_BRIDGE_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [3:0]  reg_addr;
  logic        wr_data, rd_data, wr_status, wr_baud;
  logic        tx_full, tx_empty, tx_pop;
  logic [7:0]  tx_head;
  logic        rx_full, rx_empty, rx_rise;
  logic [7:0]  rx_head;
  logic        ov_q;
  logic        overrun_q, overrun_d;
  logic [31:0] baud_q, baud_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [31:0] status;
  tx_state_t   state_q, state_d;
  logic        wait_cnt_q, wait_cnt_d;
  logic        unused_addr;

  assign reg_addr    = {addr[3:2], 2'b00};
  assign unused_addr = ^addr[1:0];
  assign wr_data     = we && (reg_addr == REG_DATA);
  assign rd_data     = re && (reg_addr == REG_DATA);
  assign wr_status   = we && (reg_addr == REG_STATUS);
  assign wr_baud     = we && (reg_addr == REG_BAUD);

  assign tx_pop         = (state_q == ISSUE);
  assign u_write_enable = (state_q == ISSUE);
  assign u_data         = (state_q == ISSUE) ? tx_head : 8'h00;
  assign rx_rise        = u_out_valid & ~ov_q;

  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign baud_rate     = baud_q;
  assign clk_frequency = CLK_FREQ;

  uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_rise),
    .pop   (rd_data),
    .din   (u_rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // WAIT_HI gives the Uart two cycles to raise busy; otherwise the byte is abandoned.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE:    if (!tx_empty && !u_busy) state_d = ISSUE;
      ISSUE: begin
        state_d    = WAIT_HI;
        wait_cnt_d = 1'b0;
      end
      WAIT_HI: begin
        if (u_busy)          state_d = WAIT_LO;
        else if (wait_cnt_q) state_d = IDLE;
        else                 wait_cnt_d = 1'b1;
      end
      WAIT_LO: if (!u_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A concurrent DATA read frees a slot, so a full RX FIFO only overruns without one.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_status && wdata[ST_RX_OVERRUN]) overrun_d = 1'b0;
    if (rx_rise && rx_full && !rd_data)   overrun_d = 1'b1;
  end

  always_comb begin
    baud_d = baud_q;
    if (wr_baud && (wdata != 32'd0)) baud_d = wdata;
  end

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_VALID]   = ~rx_empty;
    status[ST_RX_OVERRUN] = overrun_q;
    status[ST_BUSY]       = u_busy;
  end

`ifdef UART_BRIDGE_IRQ_EN
  logic [1:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  assign irq = irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (we && (reg_addr == REG_IRQ_EN)) irq_en_d = wdata[1:0];
    irq_d = (irq_en_q[IE_RX] & ~rx_empty) |
            (irq_en_q[IE_TX] & tx_empty & (state_q == IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      REG_DATA:   if (!rx_empty) rdata_d = {24'h0, rx_head};
      REG_STATUS: rdata_d = status;
      REG_BAUD:   rdata_d = baud_q;
`ifdef UART_BRIDGE_IRQ_EN
      REG_IRQ_EN: rdata_d = {30'h0, irq_en_q};
`endif
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 1'b0;
      ov_q       <= 1'b0;
      overrun_q  <= 1'b0;
      baud_q     <= BAUD_RST;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ov_q       <= u_out_valid;
      overrun_q  <= overrun_d;
      baud_q     <= baud_d;
      rvalid_q   <= re;
      if (re) rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_bridge.sv
// Self-checking bench for uart_bridge: behavioural Uart/queue models, randomized
// TX/RX traffic. IRQ checks are compiled in with UART_BRIDGE_IRQ_EN.
module tb_uart_bridge;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        we, re;
  logic [31:0] rdata;
  logic        rvalid;
  logic        u_write_enable;
  logic [7:0]  u_data;
  logic        u_busy;
  logic [7:0]  u_rx_data;
  logic        u_out_valid;
  logic [31:0] baud_rate;
  logic [31:0] clk_frequency;
`ifdef UART_BRIDGE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  // Uart model state
  int         busy_len  = 20;
  int         busy_cnt  = 0;
  logic       hold_busy = 1'b0;
  logic       prev_we   = 1'b0;
  logic [7:0] tx_got[$];

  // Reference model of software-visible state
  logic [7:0]  rx_q[$];
  logic        ovr_m;
  logic [31:0] baud_m;

  always #5 clk = ~clk;

  assign u_busy = hold_busy | (busy_cnt != 0);

  uart_bridge #(
    .DEPTH   (DEPTH),
    .CLK_FREQ(32'd50_000_000),
    .BAUD_RST(32'd115200)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .we            (we),
    .re            (re),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .u_write_enable(u_write_enable),
    .u_data        (u_data),
    .u_busy        (u_busy),
    .u_rx_data     (u_rx_data),
    .u_out_valid   (u_out_valid),
    .baud_rate     (baud_rate),
    .clk_frequency (clk_frequency)
`ifdef UART_BRIDGE_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  // Uart model: accepts a byte on each write_enable and stays busy busy_len cycles.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      prev_we  = 1'b0;
    end else begin
      if (u_write_enable) begin
        checks++;
        if (u_busy !== 1'b0) begin
          errors++;
          $display("FAIL we_while_busy: got busy=%0b required 0", u_busy);
        end
        checks++;
        if (prev_we !== 1'b0) begin
          errors++;
          $display("FAIL we_back_to_back: got consecutive pulses required gap");
        end
        $display("TX byte 0x%02h", u_data);
        tx_got.push_back(u_data);
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      prev_we = u_write_enable;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic inject(input logic [7:0] b);
    u_rx_data = b; u_out_valid = 1'b1;
    @(negedge clk);
    u_out_valid = 1'b0;
    @(negedge clk);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  function automatic logic [31:0] exp_status(input logic tx_full_m, input logic tx_empty_m);
    exp_status = {27'h0, u_busy, ovr_m, (rx_q.size() != 0), tx_empty_m, tx_full_m};
  endfunction

  task automatic wait_tx(input int n);
    for (int c = 0; c < 3000; c++) begin
      if (tx_got.size() >= n && !u_busy) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    ovr_m  = 1'b0;
    baud_m = 32'd115200;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %0h required 0", rdata); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b required 0", rvalid); end
    checks++; if (u_write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b required 0", u_write_enable); end
    checks++; if (u_data !== 8'h0) begin errors++; $display("FAIL rst_udata: got %0h required 0", u_data); end
    checks++; if (baud_rate !== 32'd115200) begin errors++; $display("FAIL rst_baud_port: got %0d required 115200", baud_rate); end
    checks++; if (clk_frequency !== 32'd50_000_000) begin errors++; $display("FAIL clk_freq: got %0d required 50000000", clk_frequency); end
    rd(4'h4, d);
    $display("READ STATUS 0x%08h", d);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_pulse: got %0b required 1", rvalid); end
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rst_status: got %0h required 2", d); end
    rd(4'h8, d);
    checks++; if (d !== 32'd115200) begin errors++; $display("FAIL rst_baud: got %0d required 115200", d); end
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_clear: got %0b required 0", rvalid); end
  endtask

  task automatic test_tx_order();
    logic [7:0] exp[$];
    tx_got.delete();
    busy_len = 20;
    exp = '{8'h41, 8'h42, 8'h43};
    foreach (exp[i]) wr(4'h0, {24'h0, exp[i]});
    wait_tx(3);
    checks++;
    if (tx_got.size() !== 3) begin errors++; $display("FAIL tx_order_count: got %0d required 3", tx_got.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (tx_got[i] !== exp[i]) begin errors++; $display("FAIL tx_order[%0d]: got %02h required %02h", i, tx_got[i], exp[i]); end
    end
  endtask

  task automatic test_tx_random();
    logic [7:0] exp[$];
    logic [7:0] b;
    int n;
    for (int r = 0; r < 4; r++) begin
      tx_got.delete(); exp.delete();
      busy_len = (r == 0) ? 0 : $urandom_range(1, 12);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp.push_back(b);
        wr(4'h0, {24'h0, b});
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_tx(n);
      checks++;
      if (tx_got.size() !== n) begin errors++; $display("FAIL tx_rand_count: got %0d required %0d", tx_got.size(), n); end
      else foreach (exp[i]) begin
        checks++;
        if (tx_got[i] !== exp[i]) begin errors++; $display("FAIL tx_rand[%0d]: got %02h required %02h", i, tx_got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    logic [7:0] exp[$];
    tx_got.delete();
    busy_len  = 3;
    hold_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr(4'h0, 32'h60 + i);
      if (i < DEPTH) exp.push_back(8'(8'h60 + i));
    end
    rd(4'h4, d);
    checks++;
    if (d[0] !== 1'b1) begin errors++; $display("FAIL tx_full_flag: got %0b required 1", d[0]); end
    checks++;
    if (tx_got.size() !== 0) begin errors++; $display("FAIL tx_sent_while_busy: got %0d required 0", tx_got.size()); end
    hold_busy = 1'b0;
    wait_tx(DEPTH);
    checks++;
    if (tx_got.size() !== DEPTH) begin errors++; $display("FAIL tx_full_count: got %0d required %0d", tx_got.size(), DEPTH); end
    else foreach (exp[i]) begin
      checks++;
      if (tx_got[i] !== exp[i]) begin errors++; $display("FAIL tx_full[%0d]: got %02h required %02h", i, tx_got[i], exp[i]); end
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d, e;
    for (int i = 0; i < DEPTH + 1; i++) inject(8'(8'h10 + i));
    e = exp_status(1'b0, 1'b1);
    rd(4'h4, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL rx_ovr_status: got %0h required %0h", d, e); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
      rd(4'h0, d);
      $display("RX read 0x%02h", d[7:0]);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rx_ovr_data[%0d]: got %0h required %0h", i, d, e); end
    end
    wr(4'h4, 32'h8);
    ovr_m = 1'b0;
    e = exp_status(1'b0, 1'b1);
    rd(4'h4, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL rx_ovr_clear: got %0h required %0h", d, e); end
  endtask

  task automatic test_rx_boundary();
    logic [31:0] d, e;
    logic [7:0] hb;
    for (int i = 0; i < DEPTH; i++) inject(8'($urandom));
    addr = 4'h0; re = 1'b1; u_rx_data = 8'h55; u_out_valid = 1'b1;
    @(negedge clk);
    re = 1'b0; u_out_valid = 1'b0;
    e = {24'h0, rx_q.pop_front()};
    rx_q.push_back(8'h55);
    checks++;
    if (rdata !== e) begin errors++; $display("FAIL rx_same_cycle_read: got %0h required %0h", rdata, e); end
    @(negedge clk);
    e = exp_status(1'b0, 1'b1);
    rd(4'h4, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL rx_bound_status: got %0h required %0h", d, e); end
    for (int i = 0; i < DEPTH; i++) begin
      e = {24'h0, rx_q.pop_front()};
      rd(4'h0, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rx_bound_data[%0d]: got %0h required %0h", i, d, e); end
    end
    hb = 8'($urandom);
    u_rx_data = hb; u_out_valid = 1'b1;
    repeat (100) @(negedge clk);
    u_out_valid = 1'b0;
    @(negedge clk);
    rd(4'h0, d);
    checks++;
    if (d !== {24'h0, hb}) begin errors++; $display("FAIL rx_held_first: got %0h required %0h", d, hb); end
    rd(4'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rx_held_once: got %0h required 0", d); end
  endtask

  task automatic test_rx_random();
    logic [31:0] d, e;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) inject(8'($urandom));
      else begin
        e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
        rd(4'h0, d);
        checks++;
        if (d !== e) begin errors++; $display("FAIL rx_rand_data[%0d]: got %0h required %0h", i, d, e); end
      end
    end
    e = exp_status(1'b0, 1'b1);
    rd(4'h4, d);
    checks++;
    if (d !== e) begin errors++; $display("FAIL rx_rand_status: got %0h required %0h", d, e); end
    wr(4'h4, 32'h8); ovr_m = 1'b0;
    while (rx_q.size() != 0) begin
      e = {24'h0, rx_q.pop_front()};
      rd(4'h0, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rx_drain: got %0h required %0h", d, e); end
    end
  endtask

  task automatic test_baud();
    logic [31:0] d, v;
    wr(4'h8, 32'h0);
    rd(4'h8, d);
    checks++;
    if (d !== baud_m) begin errors++; $display("FAIL baud_zero: got %0d required %0d", d, baud_m); end
    wr(4'h8, 32'd9600); baud_m = 32'd9600;
    rd(4'h8, d);
    checks++;
    if (d !== 32'd9600) begin errors++; $display("FAIL baud_9600: got %0d required 9600", d); end
    v = $urandom | 32'h1; baud_m = v;
    wr(4'h9, v);
    checks++;
    if (baud_rate !== v) begin errors++; $display("FAIL baud_port: got %0h required %0h", baud_rate, v); end
`ifndef UART_BRIDGE_IRQ_EN
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_0xC: got %0h required 0", d); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n;
    tx_got.delete();
    busy_len = 40;
    wr(4'h0, 32'hA1); wr(4'h0, 32'hA2); wr(4'h0, 32'hA3);
    inject(8'h77);
    for (int c = 0; c < 100 && tx_got.size() == 0; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    do_reset();
    n = tx_got.size();
    rd(4'h4, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_mid_status: got %0h required 2", d); end
    repeat (30) @(negedge clk);
    checks++;
    if (tx_got.size() !== n) begin errors++; $display("FAIL reset_mid_tx: got %0d pulses required %0d", tx_got.size(), n); end
  endtask

`ifdef UART_BRIDGE_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    wr(4'hC, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %0b required 0", irq); end
    inject(8'h5A);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_set: got %0b required 1", irq); end
    rd(4'h0, d); void'(rx_q.pop_front());
    checks++;
    if (d !== 32'h5A) begin errors++; $display("FAIL irq_rx_data: got %0h required 5a", d); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_clear: got %0b required 0", irq); end
    wr(4'hC, 32'h2);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %0b required 1", irq); end
    wr(4'hC, 32'h0);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %0b required 0", irq); end
  endtask
`endif

  initial begin
    #600_000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    u_rx_data = '0; u_out_valid = 1'b0;
    ovr_m = 1'b0; baud_m = 32'd115200;
    @(negedge clk);
    test_reset();
    test_tx_order();
    test_tx_random();
    test_tx_full();
    test_rx_overrun();
    test_rx_boundary();
    test_rx_random();
    test_baud();
`ifdef UART_BRIDGE_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bridge.md
# uart_bridge

- Memory-mapped front end between the core's load/store path and the `Uart` serial engine.
- Buffers outgoing bytes in a TX FIFO and drains them into `Uart` one at a time using its `write_enable`/`busy` handshake.
- Captures each received byte on the rising edge of `outValid` into an RX FIFO.
- Exposes data, status and baud registers to software.

## Interface
- `DEPTH`, 8 — entries per FIFO; power of two, at least 2.
- `CLK_FREQ`, 32'd50_000_000 — driven constantly on `clk_frequency`.
- `BAUD_RST`, 32'd115200 — reset value of the BAUD register.
- `clk` input 1 — single clock.
- `rst` input 1 — reset; synchronous, active-high.
- `addr` input 4 — byte address of the register; bits [1:0] are ignored.
- `wdata` input 32 — write data.
- `we` input 1 — write strobe; one access per cycle.
- `re` input 1 — read strobe; never asserted together with `we`.
- `rdata` output 32 — registered read data.
- `rvalid` output 1 — pulses one cycle after `re`.
- `u_write_enable` output 1 — to `Uart.write_enable`.
- `u_data` output 8 — to `Uart.data`.
- `u_busy` input 1 — from `Uart.busy`.
- `u_rx_data` input 8 — from `Uart.rx_data`.
- `u_out_valid` input 1 — from `Uart.outValid`.
- `baud_rate` output 32 — BAUD register value, to `Uart.baud_rate`.
- `clk_frequency` output 32 — equals `CLK_FREQ`.
- `irq` output 1 — present only with `UART_BRIDGE_IRQ_EN`.

## Operation
Register map:
- 0x0 DATA
  - Write: pushes `wdata[7:0]` into the TX FIFO. Dropped silently when the FIFO is full.
  - Read: pops the RX head into `rdata[7:0]`, upper bits zero. When RX is empty, returns 0 and does not pop.
- 0x4 STATUS
  - Read fields: bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_valid` (RX not empty), bit3 `rx_overrun`, bit4 `u_busy`.
  - Writing 1 to bit3 clears `rx_overrun`. All other bits are read-only.
- 0x8 BAUD
  - Read/write, full 32 bits.
  - Writing 0 is ignored, to protect the divider in `Uart`.
- 0xC IRQ_EN — see Configuration.
- Unmapped addresses read 0; writes to them are ignored.

TX drain FSM:
- IDLE — FIFO not empty and `u_busy`=0 → go to ISSUE.
- ISSUE — `u_write_enable`=1 for exactly one cycle with `u_data` = FIFO head. Pop the head in this cycle. Go to WAIT_HI.
- WAIT_HI — wait for `u_busy`=1, then go to WAIT_LO. If `u_busy` is still 0 after 2 cycles, go to IDLE (the byte is lost; must not hang).
- WAIT_LO — wait for `u_busy`=0, then go to IDLE.

RX capture:
- Register `u_out_valid` to detect its rising edge.
- On the cycle `u_out_valid` goes 0→1, push `u_rx_data` into the RX FIFO.
- If RX is full, discard the byte and set `rx_overrun`.
  - Exception: if a DATA read pops in the same cycle, both the push and the pop succeed and no overrun is flagged.
- TX FIFO push and pop in the same cycle (including when full) both succeed, occupancy unchanged.
  - A full-FIFO write is accepted only if the FSM pops in the same cycle.
- FIFO pointers are `$clog2(DEPTH)+1` bits; full/empty are decided by MSB comparison.

## Timing
Reset values:
- `rdata`=0, `rvalid`=0, `u_write_enable`=0, `u_data`=0.
- `baud_rate`=`BAUD_RST`, `irq`=0, `rx_overrun`=0.
- Both FIFOs empty, FSM in IDLE, edge-detect register 0.

Latencies:
- Reads: `rdata`/`rvalid` appear on the clock after `re`. The RX pop takes effect at that same edge.
- TX: a DATA write to an empty FIFO while `u_busy`=0 gives `u_write_enable` high 2 cycles after `we` (FIFO write, then ISSUE).
- Between consecutive bytes, `u_write_enable` never pulses while `u_busy`=1, and never pulses in two consecutive cycles.
- RX: a byte appears in `rx_valid` one cycle after the `u_out_valid` edge.

Reset mid-operation:
- Reset during WAIT_LO aborts the transfer and empties both FIFOs.
- `Uart` shares `rst`, so no stale `busy` survives.

## Configuration
`UART_BRIDGE_IRQ_EN` defined:
- Adds the `irq` output and the 0xC IRQ_EN register (bit0 `rx_ie`, bit1 `tx_ie`, reset 0).
- `irq` is registered: (`rx_ie` & `rx_valid`) | (`tx_ie` & `tx_empty` & FSM IDLE).
- `irq` updates one cycle after its inputs change.

`UART_BRIDGE_IRQ_EN` not defined:
- No `irq` port; 0xC reads 0 and ignores writes.

## Structure
- Package `uart_bridge_pkg`:
  - Register offsets as localparams: `REG_DATA`, `REG_STATUS`, `REG_BAUD`, `REG_IRQ_EN`.
  - STATUS bit indices.
  - `tx_state_t` enum: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- Sub-module `uart_fifo` (parameters `WIDTH`, `DEPTH`; ports push, pop, din, dout, full, empty):
  - Synchronous, with first-word fall-through `dout`.
  - Instantiated twice, once for TX and once for RX.

## Test plan
- **Reset state:** assert `rst` for 2 cycles → STATUS reads 0x02, BAUD reads 115200, `u_write_enable`=0.
- **TX ordering:** write 0x41, 0x42, 0x43 to DATA back-to-back with the `Uart` model busy for 20 cycles per byte → exactly three `u_write_enable` pulses carrying 0x41, 0x42, 0x43 in order, each with `u_busy`=0.
- **TX full:** write 9 bytes with `DEPTH`=8 while `u_busy` is held 1 → STATUS bit0=1; after release, exactly 8 bytes are sent and the 9th is dropped.
- **RX overrun:** inject 9 `u_out_valid` edges with `u_rx_data` 0x10..0x18 and no reads → `rx_overrun`=1; reads return 0x10..0x17, then 0; writing 0x8 to STATUS clears bit3.
- **RX boundary:** RX full, DATA read in the same cycle as an `outValid` edge with 0x55 → no overrun, and 0x55 is last in order. A held `u_out_valid` (high for 100 cycles) pushes exactly once.
- **Misc:** BAUD write 0 is ignored and write 9600 reads back 9600. With `UART_BRIDGE_IRQ_EN`, setting `rx_ie` and then injecting 0x5A gives `irq`=1, which clears after the read.
